// File: rtl/ptw_dcache_arbiter.sv
// Two-walker arbiter for a shared D$ load port: round-robin grant, then the granted
// page-table walker owns the port through the tag phase until its response or kill.

package ptw_dcache_arbiter_pkg;
    typedef struct packed {
        logic [11:0] address_index;
        logic [43:0] address_tag;
        logic [63:0] data_wdata;
        logic        data_req;
        logic        data_we;
        logic [7:0]  data_be;
        logic [1:0]  data_size;
        logic        kill_req;
        logic        tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [63:0] data_rdata;
    } dcache_req_o_t;
endpackage

module ptw_dcache_arbiter_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic req0,
    input logic we0,
    input logic gnt0,
    input logic req1,
    input logic we1,
    input logic gnt1
);
    a_ro0:    assert property (@(posedge clk_i) disable iff (!rst_ni) req0 |-> !we0);
    a_ro1:    assert property (@(posedge clk_i) disable iff (!rst_ni) req1 |-> !we1);
    a_hold0:  assert property (@(posedge clk_i) disable iff (!rst_ni) (req0 && !gnt0) |=> req0);
    a_hold1:  assert property (@(posedge clk_i) disable iff (!rst_ni) (req1 && !gnt1) |=> req1);
    a_onegnt: assert property (@(posedge clk_i) disable iff (!rst_ni) !(gnt0 && gnt1));
endmodule

module ptw_dcache_arbiter
    import ptw_dcache_arbiter_pkg::*;
#(
    parameter logic RR_RESET_PRIO = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  dcache_req_i_t ptw0_req_i,
    output dcache_req_o_t ptw0_rsp_o,
    input  dcache_req_i_t ptw1_req_i,
    output dcache_req_o_t ptw1_rsp_o,
    output dcache_req_i_t cache_req_o,
    input  dcache_req_o_t cache_rsp_i,
    output logic          busy_o,
    output logic          owner_o,
    output logic          conflict_o
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TAG      = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t        state_r, state_nxt_s;
    logic          owner_r, owner_nxt_s;
    logic          last_grant_r, last_nxt_s;
    logic          run_r;
    logic          sel_s, grant_s, both_s, conflict_s;
    dcache_req_i_t sel_req_s, owner_req_s, req_s;
    dcache_req_o_t rsp0_s, rsp1_s;

    // Walker selection: sole requester wins, a tie goes to the walker not served last.
    always_comb begin
        sel_s = ~last_grant_r;
        case ({ptw1_req_i.data_req, ptw0_req_i.data_req})
            2'b01:   sel_s = 1'b0;
            2'b10:   sel_s = 1'b1;
            2'b11:   sel_s = ~last_grant_r;
            default: sel_s = ~last_grant_r;
        endcase
    end

    assign sel_req_s   = sel_s   ? ptw1_req_i : ptw0_req_i;
    assign owner_req_s = owner_r ? ptw1_req_i : ptw0_req_i;
    assign both_s      = ptw0_req_i.data_req & ptw1_req_i.data_req;
    assign grant_s     = run_r & cache_rsp_i.data_gnt & sel_req_s.data_req;

    // Transaction FSM next state and port multiplexing.
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        last_nxt_s  = last_grant_r;
        req_s       = '0;
        rsp0_s      = '0;
        rsp1_s      = '0;
        conflict_s  = 1'b0;
        rsp0_s.data_rdata = cache_rsp_i.data_rdata;
        rsp1_s.data_rdata = cache_rsp_i.data_rdata;
        case (state_r)
            IDLE: begin
                req_s             = sel_req_s;
                req_s.address_tag = 44'd0;
                req_s.tag_valid   = 1'b0;
                req_s.kill_req    = 1'b0;
                conflict_s        = both_s;
                if (grant_s) begin
                    if (sel_s) begin
                        rsp1_s.data_gnt = 1'b1;
                    end else begin
                        rsp0_s.data_gnt = 1'b1;
                    end
                    state_nxt_s = TAG;
                    owner_nxt_s = sel_s;
                    last_nxt_s  = sel_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            TAG: begin
                req_s          = owner_req_s;
                req_s.data_req = 1'b0;
                if (owner_req_s.kill_req) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                req_s           = owner_req_s;
                req_s.data_req  = 1'b0;
                req_s.tag_valid = 1'b0;
                // A kill wins over a same-cycle response: the walker has abandoned it.
                if (owner_req_s.kill_req) begin
                    state_nxt_s = IDLE;
                end else if (cache_rsp_i.data_rvalid) begin
                    if (owner_r) begin
                        rsp1_s.data_rvalid = 1'b1;
                    end else begin
                        rsp0_s.data_rvalid = 1'b1;
                    end
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_RSP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Outputs stay quiet until the first clock after reset release.
    always_comb begin
        if (run_r) begin
            cache_req_o = req_s;
            ptw0_rsp_o  = rsp0_s;
            ptw1_rsp_o  = rsp1_s;
            conflict_o  = conflict_s;
        end else begin
            cache_req_o = '0;
            ptw0_rsp_o  = '0;
            ptw1_rsp_o  = '0;
            conflict_o  = 1'b0;
        end
    end

    assign busy_o  = (state_r != IDLE);
    assign owner_o = owner_r;

    // State, ownership and round-robin history registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= IDLE;
            owner_r      <= 1'b0;
            last_grant_r <= ~RR_RESET_PRIO;
            run_r        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            owner_r      <= owner_nxt_s;
            last_grant_r <= last_nxt_s;
            run_r        <= 1'b1;
        end
    end

    ptw_dcache_arbiter_chk u_chk (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req0   (ptw0_req_i.data_req),
        .we0    (ptw0_req_i.data_we),
        .gnt0   (ptw0_rsp_o.data_gnt),
        .req1   (ptw1_req_i.data_req),
        .we1    (ptw1_req_i.data_we),
        .gnt1   (ptw1_rsp_o.data_gnt)
    );
endmodule
